// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer:
// FSM state encoding, default operand width and the bit-counter width helper.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIN  = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 16;

   // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice;
   // never let it collapse to zero bits.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/add1b.sv
// Single 1-bit full-adder cell shared by the serial datapaths.
module add1b (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic r,
   output logic co
);

   assign r  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: operands are shifted LSB-first through
// one full-adder cell, one bit per clock, and the result is returned with
// carry-out and signed overflow on a start/done handshake.
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum_bit;
   logic             carry_out;
   logic             last_bit;

   add1b u_add1b (
      .a  (op_a[0]),
      .b  (op_b[0]),
      .ci (carry),
      .r  (sum_bit),
      .co (carry_out)
   );

   assign last_bit = (cnt == CW'(WIDTH - 1));

   // Controller, operand shift registers and flag capture. On the MSB cycle
   // the carry flop still holds the carry into the MSB, so signed overflow is
   // that carry XOR the cell's carry-out; the flags are registered so they
   // appear together with the done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         acc      <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE, FIN: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               acc   <= {sum_bit, acc[WIDTH-1:1]};
               op_a  <= {1'b0, op_a[WIDTH-1:1]};
               op_b  <= {1'b0, op_b[WIDTH-1:1]};
               carry <= carry_out;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  result   <= {sum_bit, acc[WIDTH-1:1]};
                  cout     <= carry_out;
                  overflow <= carry ^ carry_out;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= FIN;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed cases, random operations against an
// arithmetic reference model, ignored start, mid-operation reset and
// back-to-back throughput.
module tb_serial_add_ctrl;

   localparam int W = 16;
   localparam int LAT = W + 1;

   logic          clk;
   logic          reset;
   logic          start;
   logic          sub;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          overflow;

   int            total;
   int            bad;
   logic [W-1:0]  model_result;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic, overflow from the true signed result
   task automatic model(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        output logic [W-1:0] r, output logic c, output logic o);
      longint ua;
      longint ub;
      longint sa;
      longint sb;
      longint full;
      longint sres;
      ua = longint'(ia);
      ub = longint'(ib);
      sa = (ua >= (64'sd1 <<< (W - 1))) ? ua - (64'sd1 <<< W) : ua;
      sb = (ub >= (64'sd1 <<< (W - 1))) ? ub - (64'sd1 <<< W) : ub;
      if (isub) begin
         full = ua + ((64'sd1 <<< W) - ub);
         sres = sa - sb;
      end else begin
         full = ua + ub;
         sres = sa + sb;
      end
      r = full[W-1:0];
      c = full[W];
      o = (sres > ((64'sd1 <<< (W - 1)) - 1)) || (sres < -(64'sd1 <<< (W - 1)));
   endtask

   // Launch one operation and wait (bounded) for done; leaves time in the done cycle
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         output int lat, output int busy_bad, output int hold_bad,
                         output logic busy_fin);
      a = ia;
      b = ib;
      sub = isub;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
      lat = -1;
      busy_bad = 0;
      hold_bad = 0;
      busy_fin = 1'bx;
      for (int k = 1; k <= 40; k++) begin
         if (done === 1'b1) begin
            lat = k;
            busy_fin = busy;
            break;
         end
         if (busy !== 1'b1) busy_bad++;
         if (result !== model_result) hold_bad++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      sub = 1'b0;
      a = '1;
      b = '1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, result, cout, overflow} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL reset_state: got busy=%b done=%b result=%h cout=%b ovf=%b required all zero",
                  busy, done, result, cout, overflow);
      end
      reset = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_start_dropped: got busy=%b required 0", busy);
      end
      model_result = '0;
   endtask

   task automatic test_directed();
      logic [W-1:0] va [6] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0003};
      logic [W-1:0] vb [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0004};
      logic         vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] er [6] = '{16'h0002, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0007};
      logic         ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic         eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      int lat, busy_bad, hold_bad;
      logic busy_fin;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], vs[i], lat, busy_bad, hold_bad, busy_fin);
         total++;
         if (lat != LAT) begin
            bad++;
            $display("[TB] FAIL directed%0d_latency: got %0d required %0d", i, lat, LAT);
         end
         total++;
         if (busy_bad != 0 || busy_fin !== 1'b0) begin
            bad++;
            $display("[TB] FAIL directed%0d_busy: got %0d low cycles, busy_at_done=%b required 0/0",
                     i, busy_bad, busy_fin);
         end
         total++;
         if (hold_bad != 0) begin
            bad++;
            $display("[TB] FAIL directed%0d_hold: got %0d early result changes required 0", i, hold_bad);
         end
         total++;
         if ({result, cout, overflow} !== {er[i], ec[i], eo[i]}) begin
            bad++;
            $display("[TB] FAIL directed%0d_result: got %h/%b/%b required %h/%b/%b",
                     i, result, cout, overflow, er[i], ec[i], eo[i]);
         end
         model_result = er[i];
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL directed%0d_done_width: got done=%b required 0", i, done);
         end
      end
   endtask

   task automatic test_ignored_start();
      int ndone = 0;
      int first = -1;
      logic [W-1:0] got = '0;
      a = 16'h1234;
      b = 16'h1111;
      sub = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= LAT + 20; k++) begin
         if (k == 5) begin
            a = 16'hFFFF;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            ndone++;
            if (first < 0) begin
               first = k;
               got = result;
            end
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      total++;
      if (ndone != 1 || first != LAT) begin
         bad++;
         $display("[TB] FAIL ignored_start_done: got %0d pulses first at %0d required 1 at %0d",
                  ndone, first, LAT);
      end
      total++;
      if (got !== 16'h2345) begin
         bad++;
         $display("[TB] FAIL ignored_start_result: got %h required 2345", got);
      end
      model_result = 16'h2345;
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      int lat, busy_bad, hold_bad;
      logic busy_fin;
      a = 16'h00FF;
      b = 16'h0001;
      sub = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k < 8; k++) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total++;
      if ({busy, done, result, cout, overflow} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL reset_mid_state: got busy=%b done=%b result=%h cout=%b ovf=%b required all zero",
                  busy, done, result, cout, overflow);
      end
      model_result = '0;
      for (int k = 0; k < 30; k++) begin
         if (done === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      total++;
      if (ndone != 0) begin
         bad++;
         $display("[TB] FAIL reset_mid_no_done: got %0d pulses required 0", ndone);
      end
      run_op(16'h0003, 16'h0004, 1'b0, lat, busy_bad, hold_bad, busy_fin);
      total++;
      if (lat != LAT || result !== 16'h0007) begin
         bad++;
         $display("[TB] FAIL reset_mid_next_op: got lat=%0d result=%h required %0d/0007", lat, result, LAT);
      end
      model_result = 16'h0007;
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb, er;
      logic rs, ec, eo;
      int lat, busy_bad, hold_bad;
      logic busy_fin;
      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         if (i % 5 == 0) ra[W-1] = ~rb[W-1] ^ rs;
         model(ra, rb, rs, er, ec, eo);
         run_op(ra, rb, rs, lat, busy_bad, hold_bad, busy_fin);
         total++;
         if (lat != LAT || busy_bad != 0 || hold_bad != 0 || busy_fin !== 1'b0) begin
            bad++;
            $display("[TB] FAIL random%0d_timing: got lat=%0d busy_bad=%0d hold_bad=%0d busy_fin=%b required %0d/0/0/0",
                     i, lat, busy_bad, hold_bad, busy_fin, LAT);
         end
         total++;
         if ({result, cout, overflow} !== {er, ec, eo}) begin
            bad++;
            $display("[TB] FAIL random%0d_result: %h %s %h got %h/%b/%b required %h/%b/%b",
                     i, ra, rs ? "-" : "+", rb, result, cout, overflow, er, ec, eo);
         end
         model_result = er;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_back_to_back();
      int ntimes = 0;
      int times [8];
      int busy_bad = 0;
      int res_bad = 0;
      int k;
      a = 16'h0010;
      b = 16'h0020;
      sub = 1'b0;
      start = 1'b1;
      for (k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (busy !== ~done) busy_bad++;
         if (done === 1'b1) begin
            if (ntimes < 8) times[ntimes] = k;
            ntimes++;
            if (result !== 16'h0030) res_bad++;
         end
      end
      start = 1'b0;
      total++;
      if (ntimes != 3 || times[0] != LAT || times[1] != 2 * LAT || times[2] != 3 * LAT) begin
         bad++;
         $display("[TB] FAIL b2b_done_spacing: got %0d pulses at %0d,%0d,%0d required 3 at %0d,%0d,%0d",
                  ntimes, times[0], times[1], times[2], LAT, 2 * LAT, 3 * LAT);
      end
      total++;
      if (busy_bad != 0) begin
         bad++;
         $display("[TB] FAIL b2b_busy: got %0d cycles with busy==done required 0", busy_bad);
      end
      total++;
      if (res_bad != 0) begin
         bad++;
         $display("[TB] FAIL b2b_result: got %0d wrong results required 0", res_bad);
      end
      k = 0;
      while (done !== 1'b1 && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (done !== 1'b1 || result !== 16'h0030) begin
         bad++;
         $display("[TB] FAIL b2b_drain: got done=%b result=%h required 1/0030", done, result);
      end
      model_result = 16'h0030;
      @(posedge clk); #1;
   endtask

   // Scenario sequence
   initial begin
      total = 0;
      bad = 0;
      model_result = '0;
      reset = 1'b1;
      start = 1'b0;
      sub = 1'b0;
      a = '0;
      b = '0;
      test_reset();
      test_directed();
      test_ignored_start();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
